// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared FSM state type and default widths for the crossbar divider
package crossbar_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
  localparam int RES_W = 8;
  localparam int W_W = 4;
  localparam int CNT_W = $clog2(RES_W);
endpackage

// File: rtl/crossbar_div_step.sv
// crossbar_div_step: one combinational restoring shift-subtract step
module crossbar_div_step #(
  parameter int W_W = crossbar_pkg::W_W
) (
  input  logic [W_W-1:0] r,
  input  logic           q_msb,
  input  logic [W_W-1:0] divisor,
  output logic [W_W-1:0] r_next,
  output logic           q_bit
);
  logic [W_W:0] r_sh;
  assign r_sh = {r, q_msb};
  assign q_bit = r_sh >= {1'b0, divisor};
  // result is < divisor whenever the subtract happens, so the top bit is always zero
  assign r_next = q_bit ? W_W'(r_sh - {1'b0, divisor}) : r_sh[W_W-1:0];
endmodule

// File: rtl/crossbar_divider.sv
// crossbar_divider: recovers quotient/remainder of a crossbar result by its weight,
// one restoring quotient bit per clock, valid/ready on both sides.
module crossbar_divider #(
  parameter int RES_W = crossbar_pkg::RES_W,
  parameter int W_W = crossbar_pkg::W_W
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] dividend,
  input  logic [W_W-1:0]   divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] quotient,
  output logic [W_W-1:0]   remainder,
  output logic             div_by_zero
);
  import crossbar_pkg::*;
  localparam int CNT_W = $clog2(RES_W);
  div_state_t state_q, state_d;
  logic [RES_W-1:0] q_q, q_d;
  logic [W_W-1:0] r_q, r_d, dvs_q, dvs_d, r_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d, q_bit, accept, zero_dvs;
  assign accept = in_valid && in_ready;
  assign zero_dvs = divisor == '0;
  crossbar_div_step #(.W_W(W_W)) u_step (
    .r(r_q),
    .q_msb(q_q[RES_W-1]),
    .divisor(dvs_q),
    .r_next(r_step),
    .q_bit(q_bit)
  );
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = zero_dvs ? DONE : CALC;
      CALC: if (cnt_q == '0) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state_q == IDLE;
    out_valid = state_q == DONE;
    // results are only exposed while valid, so partial quotients never leak out
    quotient = out_valid ? q_q : '0;
    remainder = out_valid ? r_q : '0;
    div_by_zero = out_valid && dbz_q;
  end
  always_comb begin
    q_d = q_q;
    r_d = r_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    if (accept) begin
      dvs_d = divisor;
      dbz_d = zero_dvs;
      q_d = zero_dvs ? '1 : dividend;
      r_d = zero_dvs ? dividend[W_W-1:0] : '0;
      cnt_d = CNT_W'(RES_W - 1);
    end else if (state_q == CALC) begin
      q_d = {q_q[RES_W-2:0], q_bit};
      r_d = r_step;
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
      r_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      q_q <= q_d;
      r_q <= r_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      dbz_q <= dbz_d;
    end
  end
endmodule
